// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: add/sub/compare/logic in one cycle, shifts
// iterated SHIFT_STEP bits per cycle, result held with Z/C/N/V/err flags.
module alu_seq #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v,
  output logic             err,
  output logic             busy
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [SW-1:0] STEP_W = SW'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_reg;
  logic [SW-1:0]    rem;
  logic [3:0]       shift_op;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic             borrow;
  logic             v_add;
  logic             v_sub;
  logic [SW-1:0]    amt;
  logic             start_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic [SW-1:0]    step_k;
  logic [SW-1:0]    rem_next;
  logic [WIDTH-1:0] sh_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);

  // Shared adder paths: SUB/SLT/SLTU all use A + ~B + 1
  assign add_w  = {1'b0, src_a} + {1'b0, src_b};
  assign sub_w  = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
  assign borrow = ~sub_w[WIDTH];
  assign v_add  = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_w[WIDTH-1] != src_a[WIDTH-1]);
  assign v_sub  = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_w[WIDTH-1] != src_a[WIDTH-1]);
  assign amt    = src_b[SW-1:0];
  assign start_shift = ((op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA)) && (amt != '0);

  // Single-cycle result; shifts only reach here with a zero amount
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = v_add;
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = borrow;
        alu_v   = v_sub;
      end
      OP_SLT: begin
        alu_res = WIDTH'(sub_w[WIDTH-1] ^ v_sub);
        alu_c   = borrow;
        alu_v   = v_sub;
      end
      OP_SLTU: begin
        alu_res = WIDTH'(borrow);
        alu_c   = borrow;
        alu_v   = v_sub;
      end
      OP_XOR: alu_res = src_a ^ src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_AND: alu_res = src_a & src_b;
      OP_SLL, OP_SRL, OP_SRA: alu_res = src_a;
      default: alu_err = 1'b1;
    endcase
  end

  // One iteration of the shifter: k = min(SHIFT_STEP, rem)
  always_comb begin
    step_k   = (rem > STEP_W) ? STEP_W : rem;
    rem_next = rem - step_k;
    case (shift_op)
      OP_SLL:  sh_next = sh_reg << step_k;
      OP_SRA:  sh_next = WIDTH'($signed(sh_reg) >>> step_k);
      default: sh_next = sh_reg >> step_k;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh_reg   <= '0;
      rem      <= '0;
      shift_op <= '0;
      result   <= '0;
      z        <= 1'b0;
      c        <= 1'b0;
      n        <= 1'b0;
      v        <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start_shift) begin
              sh_reg   <= src_a;
              rem      <= amt;
              shift_op <= op;
              state    <= SHIFT;
            end else begin
              result <= alu_res;
              z      <= (alu_res == '0);
              n      <= alu_res[WIDTH-1];
              c      <= alu_c;
              v      <= alu_v;
              err    <= alu_err;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          sh_reg <= sh_next;
          rem    <= rem_next;
          if (rem_next == '0) begin
            result <= sh_next;
            z      <= (sh_next == '0);
            n      <= sh_next[WIDTH-1];
            c      <= 1'b0;
            v      <= 1'b0;
            err    <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: SHIFT_STEP=1 and SHIFT_STEP=4 instances share stimulus and
// are checked against directed constants and an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_ready;

  logic        in_ready1, out_valid1, z1, c1, n1, v1, err1, busy1;
  logic [31:0] res1;
  logic        in_ready4, out_valid4, z4, c4, n4, v4, err4, busy4;
  logic [31:0] res4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0]  f;
    logic [7:0]  l1;
    logic [7:0]  l4;
  } vec_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid1), .out_ready(out_ready),
    .result(res1), .z(z1), .c(c1), .n(n1), .v(v1), .err(err1), .busy(busy1)
  );

  alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid4), .out_ready(out_ready),
    .result(res4), .z(z4), .c(c4), .n(n4), .v(v4), .err(err4), .busy(busy4)
  );

  // Reference: {result, z, c, n, v, err}
  function automatic logic [36:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        fc, fv, fe;
    longint      d;
    int          amt;
    amt = int'(b[4:0]);
    r = '0; fc = 1'b0; fv = 1'b0; fe = 1'b0;
    case (o)
      4'd0: begin
        w  = {1'b0, a} + {1'b0, b};
        r  = w[31:0];
        fc = w[32];
        d  = longint'($signed(a)) + longint'($signed(b));
        fv = (d != longint'($signed(r)));
      end
      4'd1, 4'd2, 4'd3: begin
        r  = a - b;
        fc = (a < b);
        d  = longint'($signed(a)) - longint'($signed(b));
        fv = (d != longint'($signed(r)));
        if (o == 4'd2) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (o == 4'd3) r = (a < b) ? 32'd1 : 32'd0;
      end
      4'd4: r = a ^ b;
      4'd5: r = a | b;
      4'd6: r = a & b;
      4'd7: r = a << amt;
      4'd8: r = a >> amt;
      4'd9: r = 32'($signed(a) >>> amt);
      default: fe = 1'b1;
    endcase
    return {r, (r == 32'd0), fc, r[31], fv, fe};
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic [31:0] b, input int step);
    int amt;
    amt = int'(b[4:0]);
    if (o >= 4'd7 && o <= 4'd9 && amt != 0) return 1 + (amt + step - 1) / step;
    return 1;
  endfunction

  // Issue one op with out_ready high; capture each instance's first valid output and latency (0 = never seen)
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r1, output logic [4:0] f1, output int l1,
                       output logic [31:0] r4, output logic [4:0] f4, output int l4);
    r1 = '0; f1 = '0; l1 = 0;
    r4 = '0; f4 = '0; l4 = 0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 80 && (l1 == 0 || l4 == 0); cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (l1 == 0 && out_valid1) begin
        l1 = cyc; r1 = res1; f1 = {z1, c1, n1, v1, err1};
      end
      if (l4 == 0 && out_valid4) begin
        l4 = cyc; r4 = res4; f4 = {z4, c4, n4, v4, err4};
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] st1, st4;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    st1 = {in_ready1, out_valid1, busy1, z1, c1, n1, v1, err1};
    st4 = {in_ready4, out_valid4, busy4, z4, c4, n4, v4, err4};
    checks++; if (st1 !== 8'b1000_0000 || res1 !== 32'd0) begin errors++;
      $display("FAIL reset_dut1: got status %b result %h, want 10000000 / 0", st1, res1); end
    checks++; if (st4 !== 8'b1000_0000 || res4 !== 32'd0) begin errors++;
      $display("FAIL reset_dut4: got status %b result %h, want 10000000 / 0", st4, res4); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || in_ready4 !== 1'b1) begin errors++;
      $display("FAIL reset_release: in_ready1=%b out_valid1=%b in_ready4=%b, want 1 0 1", in_ready1, out_valid1, in_ready4); end
  endtask

  task automatic test_directed();
    vec_t dv [7];
    logic [31:0] r1, r4;
    logic [4:0]  f1, f4;
    int          l1, l4;
    dv[0] = '{op:4'd0, a:32'h7FFF_FFFF, b:32'd1, r:32'h8000_0000, f:5'b00110, l1:8'd1,  l4:8'd1};
    dv[1] = '{op:4'd1, a:32'd5,         b:32'd5, r:32'd0,         f:5'b10000, l1:8'd1,  l4:8'd1};
    dv[2] = '{op:4'd1, a:32'd0,         b:32'd1, r:32'hFFFF_FFFF, f:5'b01100, l1:8'd1,  l4:8'd1};
    dv[3] = '{op:4'd2, a:32'hFFFF_FFFF, b:32'd1, r:32'd1,         f:5'b00000, l1:8'd1,  l4:8'd1};
    dv[4] = '{op:4'd3, a:32'hFFFF_FFFF, b:32'd1, r:32'd0,         f:5'b10000, l1:8'd1,  l4:8'd1};
    dv[5] = '{op:4'd9, a:32'h8000_0000, b:32'd31, r:32'hFFFF_FFFF, f:5'b00100, l1:8'd32, l4:8'd9};
    dv[6] = '{op:4'd7, a:32'd1,         b:32'd0, r:32'd1,         f:5'b00000, l1:8'd1,  l4:8'd1};
    for (int i = 0; i < 7; i++) begin
      do_op(dv[i].op, dv[i].a, dv[i].b, r1, f1, l1, r4, f4, l4);
      checks++; if (r1 !== dv[i].r || f1 !== dv[i].f) begin errors++;
        $display("FAIL directed%0d_dut1: got %h zcnve=%b, want %h %b", i, r1, f1, dv[i].r, dv[i].f); end
      checks++; if (l1 != int'(dv[i].l1)) begin errors++;
        $display("FAIL directed%0d_lat1: got %0d, want %0d", i, l1, dv[i].l1); end
      checks++; if (r4 !== dv[i].r || f4 !== dv[i].f) begin errors++;
        $display("FAIL directed%0d_dut4: got %h zcnve=%b, want %h %b", i, r4, f4, dv[i].r, dv[i].f); end
      checks++; if (l4 != int'(dv[i].l4)) begin errors++;
        $display("FAIL directed%0d_lat4: got %0d, want %0d", i, l4, dv[i].l4); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r1, r4;
    logic [4:0]  f1, f4;
    logic [3:0]  o;
    logic [36:0] exp;
    int          l1, l4;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a = {a[31], 31'($urandom_range(0, 3))};
      if (i % 5 == 0) b = a;
      exp = model(o, a, b);
      do_op(o, a, b, r1, f1, l1, r4, f4, l4);
      checks++; if (r1 !== exp[36:5] || f1 !== exp[4:0] || l1 != model_lat(o, b, 1)) begin errors++;
        $display("FAIL random%0d_dut1 op=%0d a=%h b=%h: got %h %b lat %0d, want %h %b lat %0d",
                 i, o, a, b, r1, f1, l1, exp[36:5], exp[4:0], model_lat(o, b, 1)); end
      checks++; if (r4 !== exp[36:5] || f4 !== exp[4:0] || l4 != model_lat(o, b, 4)) begin errors++;
        $display("FAIL random%0d_dut4 op=%0d a=%h b=%h: got %h %b lat %0d, want %h %b lat %0d",
                 i, o, a, b, r4, f4, l4, exp[36:5], exp[4:0], model_lat(o, b, 4)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, r1, r4;
    logic [4:0]  f1, f4;
    logic [36:0] exp;
    int          l1, l4;
    a = $urandom; b = $urandom;
    exp = model(4'd0, a, b);
    @(negedge clk);
    op = 4'd0; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    op = 4'd1; src_a = $urandom; src_b = $urandom;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      checks++; if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || res1 !== exp[36:5] ||
                    {z1, c1, n1, v1, err1} !== exp[4:0]) begin errors++;
        $display("FAIL hold%0d_dut1: ov=%b ir=%b %h %b, want 1 0 %h %b", i, out_valid1, in_ready1,
                 res1, {z1, c1, n1, v1, err1}, exp[36:5], exp[4:0]); end
      checks++; if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || res4 !== exp[36:5] ||
                    {z4, c4, n4, v4, err4} !== exp[4:0]) begin errors++;
        $display("FAIL hold%0d_dut4: ov=%b ir=%b %h %b, want 1 0 %h %b", i, out_valid4, in_ready4,
                 res4, {z4, c4, n4, v4, err4}, exp[36:5], exp[4:0]); end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++;
      $display("FAIL release: ov1=%b ir1=%b ov4=%b ir4=%b, want 0 1 0 1", out_valid1, in_ready1, out_valid4, in_ready4); end
    do_op(4'hF, $urandom, $urandom, r1, f1, l1, r4, f4, l4);
    checks++; if (r1 !== 32'd0 || f1 !== 5'b10001 || l1 != 1) begin errors++;
      $display("FAIL illegal_dut1: got %h %b lat %0d, want 0 10001 lat 1", r1, f1, l1); end
    checks++; if (r4 !== 32'd0 || f4 !== 5'b10001 || l4 != 1) begin errors++;
      $display("FAIL illegal_dut4: got %h %b lat %0d, want 0 10001 lat 1", r4, f4, l4); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r1, r4;
    logic [4:0]  f1, f4;
    int          l1, l4;
    @(negedge clk);
    op = 4'd8; src_a = 32'hF000_0000; src_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy1 !== 1'b1 || out_valid1 !== 1'b0 || busy4 !== 1'b1) begin errors++;
      $display("FAIL mid_shift_busy: busy1=%b ov1=%b busy4=%b, want 1 0 1", busy1, out_valid1, busy4); end
    rst = 1'b1;
    #1;
    checks++; if ({in_ready1, out_valid1, busy1, z1, c1, n1, v1, err1} !== 8'b1000_0000 || res1 !== 32'd0) begin errors++;
      $display("FAIL mid_reset_dut1: got %b %h, want 10000000 0", {in_ready1, out_valid1, busy1, z1, c1, n1, v1, err1}, res1); end
    checks++; if ({in_ready4, out_valid4, busy4, z4, c4, n4, v4, err4} !== 8'b1000_0000 || res4 !== 32'd0) begin errors++;
      $display("FAIL mid_reset_dut4: got %b %h, want 10000000 0", {in_ready4, out_valid4, busy4, z4, c4, n4, v4, err4}, res4); end
    @(negedge clk);
    rst = 1'b0;
    do_op(4'd0, 32'd2, 32'd3, r1, f1, l1, r4, f4, l4);
    checks++; if (r1 !== 32'd5 || f1 !== 5'b00000 || l1 != 1) begin errors++;
      $display("FAIL post_reset_add_dut1: got %h %b lat %0d, want 5 00000 lat 1", r1, f1, l1); end
    checks++; if (r4 !== 32'd5 || f4 !== 5'b00000 || l4 != 1) begin errors++;
      $display("FAIL post_reset_add_dut4: got %h %b lat %0d, want 5 00000 lat 1", r4, f4, l4); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r4;
    logic [4:0]  f1, f4;
    int          l1, l4;
    do_op(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, r1, f1, l1, r4, f4, l4);
    do_op(4'd5, 32'h0000_00F0, 32'h0000_000F, r1, f1, l1, r4, f4, l4);
    checks++; if (r1 !== 32'h0000_00FF || l1 != 1 || r4 !== 32'h0000_00FF) begin errors++;
      $display("FAIL back_to_back: got %h lat %0d / %h, want 000000ff lat 1", r1, l1, r4); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
